// File: rtl/sqrt_arbiter_if.sv
// Requester-side request/response channels shared by N_REQ clients of the sqrt arbiter.
// The master modport is the requester side; the slave modport is the arbiter side.
interface sqrt_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W     = 64
);
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ*W-1:0] req_rad;
  logic [N_REQ-1:0]   resp_valid;
  logic [N_REQ-1:0]   resp_ready;
  logic [W-1:0]       resp_root;
  logic [W-1:0]       resp_rem;
  logic               resp_err;

  modport master (
    output req_valid, req_rad, resp_ready,
    input  req_ready, resp_valid, resp_root, resp_rem, resp_err
  );

  modport slave (
    input  req_valid, req_rad, resp_ready,
    output req_ready, resp_valid, resp_root, resp_rem, resp_err
  );
endinterface

// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter sharing one iterative square-root unit among N_REQ requesters,
// with start sequencing, completion detection, response return and a completion watchdog.
module sqrt_arbiter #(
  parameter int N_REQ   = 4,
  parameter int W       = 64,
  parameter int TIMEOUT = 63
) (
  input  logic          clk,
  input  logic          rst,
  sqrt_arbiter_if.slave bus,
  output logic          sqrt_start,
  output logic [W-1:0]  sqrt_rad,
  input  logic          sqrt_busy,
  input  logic          sqrt_valid,
  input  logic [W-1:0]  sqrt_root,
  input  logic [W-1:0]  sqrt_rem,
  output logic          timeout_err
);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] r_owner;
  logic [PTR_W-1:0] w_gnt_idx;
  logic             w_gnt_found;
  logic [W-1:0]     w_gnt_rad;
  logic [N_REQ-1:0] w_req_ready;
  logic             w_req_hs;
  logic             w_resp_hs;
  logic             w_done;
  logic             w_tmo;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_start;
  logic [W-1:0]     r_sqrt_rad;
  logic [N_REQ-1:0] r_resp_valid;
  logic [W-1:0]     r_resp_root;
  logic [W-1:0]     r_resp_rem;
  logic             r_resp_err;
  logic             r_timeout_err;

  function automatic logic [N_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_req_hs) w_state_nxt = S_LAUNCH;
      S_LAUNCH: w_state_nxt = S_WAIT;
      S_WAIT:   if (w_done || w_tmo) w_state_nxt = S_RESP;
      S_RESP:   if (w_resp_hs) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Scan downward so the requester closest to r_ptr is the last (winning) assignment.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[PTR_W'((int'(r_ptr) + i) % N_REQ)]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = PTR_W'((int'(r_ptr) + i) % N_REQ);
      end
    end
    w_gnt_rad = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_gnt_idx == PTR_W'(k)) w_gnt_rad = bus.req_rad[k*W +: W];
    end
    w_req_ready = '0;
    if (r_state == S_IDLE && w_gnt_found && !rst) w_req_ready = onehot(w_gnt_idx);
    w_req_hs  = |w_req_ready;
    w_resp_hs = (r_state == S_RESP) && bus.resp_ready[r_owner];
    w_done    = !sqrt_busy && sqrt_valid;
    w_tmo     = (r_wait_cnt == CNT_W'(TIMEOUT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr         <= '0;
      r_owner       <= '0;
      r_wait_cnt    <= '0;
      r_start       <= 1'b0;
      r_sqrt_rad    <= '0;
      r_resp_valid  <= '0;
      r_resp_root   <= '0;
      r_resp_rem    <= '0;
      r_resp_err    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_start <= (w_state_nxt == S_LAUNCH);
      case (r_state)
        S_IDLE: begin
          if (w_req_hs) begin
            r_sqrt_rad <= w_gnt_rad;
            r_owner    <= w_gnt_idx;
          end
        end
        S_LAUNCH: r_wait_cnt <= '0;
        S_WAIT: begin
          r_wait_cnt <= r_wait_cnt + 1'b1;
          // Completion wins over a timeout landing in the same cycle.
          if (w_done) begin
            r_resp_root  <= sqrt_root;
            r_resp_rem   <= sqrt_rem;
            r_resp_err   <= 1'b0;
            r_resp_valid <= onehot(r_owner);
          end else if (w_tmo) begin
            r_resp_root   <= '0;
            r_resp_rem    <= '0;
            r_resp_err    <= 1'b1;
            r_resp_valid  <= onehot(r_owner);
            r_timeout_err <= 1'b1;
          end
        end
        S_RESP: begin
          if (w_resp_hs) begin
            r_resp_valid <= '0;
            r_ptr        <= (r_owner == PTR_W'(N_REQ - 1)) ? '0 : r_owner + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_root  = r_resp_root;
  assign bus.resp_rem   = r_resp_rem;
  assign bus.resp_err   = r_resp_err;
  assign sqrt_start     = r_start;
  assign sqrt_rad       = r_sqrt_rad;
  assign timeout_err    = r_timeout_err;
endmodule

// File: doc/sqrt_arbiter.md
Name: sqrt_arbiter

Overview:
- Shares one iterative square-root unit (64-bit radicand, 48-iteration start/busy/valid datapath) among N_REQ requesters.
- Round-robin arbitration over per-requester valid/ready request channels.
- Sequences the unit's one-cycle start pulse, detects completion, and returns root/remainder to the owning requester through a valid/ready response channel.
- Includes a completion watchdog that flags a hung unit.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- W, 64, radicand/root/remainder width; matches the sqrt unit.
- TIMEOUT, 63, max WAIT cycles before error; must exceed 49.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  one-hot grant/accept, combinational, only in IDLE.
- req_rad  in  N_REQ*W  radicands; requester k uses bits [k*W +: W].
- resp_valid  out  N_REQ  one-hot response valid to owner.
- resp_ready  in  N_REQ  per-requester response accept.
- resp_root  out  W  result root, qualified by resp_valid.
- resp_rem  out  W  result remainder, qualified by resp_valid.
- resp_err  out  1  response produced by timeout; root/rem are 0.
- sqrt_start  out  1  start pulse to the sqrt unit.
- sqrt_rad  out  W  radicand to the sqrt unit, registered.
- sqrt_busy  in  1  from the sqrt unit.
- sqrt_valid  in  1  from the sqrt unit (sticky until next start).
- sqrt_root  in  W  from the sqrt unit.
- sqrt_rem  in  W  from the sqrt unit.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:

Reset values:
- state=IDLE, ptr=0, owner=0.
- req_ready=0, resp_valid=0, resp_root=0, resp_rem=0, resp_err=0.
- sqrt_start=0, sqrt_rad=0, timeout_err=0, wait_cnt=0.

States:
- IDLE
  - Select g = first k with req_valid[k], searching ptr, ptr+1, … mod N_REQ.
  - Drive req_ready[g]=1 that cycle; all other req_ready bits are 0.
  - On the handshake: sqrt_rad<=req_rad[g], owner<=g, go to LAUNCH.
  - No req_valid: stay in IDLE, req_ready=0.
- LAUNCH
  - sqrt_start=1 for exactly this cycle (registered output, high only while in LAUNCH).
  - Go to WAIT with wait_cnt<=0.
- WAIT
  - wait_cnt increments each cycle.
  - Completion = sqrt_busy==0 && sqrt_valid==1.
    - On completion: resp_root<=sqrt_root, resp_rem<=sqrt_rem, resp_err<=0, resp_valid[owner]<=1, go to RESP.
  - If wait_cnt==TIMEOUT without completion: timeout_err<=1, resp_root/rem<=0, resp_err<=1, resp_valid[owner]<=1, go to RESP.
  - Completion takes priority over timeout in the same cycle.
- RESP
  - Hold resp_* stable until resp_ready[owner].
  - On the handshake: resp_valid<=0, ptr<=(owner+1) mod N_REQ, go to IDLE.
  - resp_ready bits of non-owners are ignored.

Latency (unit ITER=48):
- Request accepted in cycle T.
- sqrt_start high in T+1.
- sqrt_busy high from T+2; completion seen in T+50.
- resp_valid high from T+51.
- If resp_ready is already high, the next grant is possible at T+52.

Rules:
- At most one outstanding operation; a requester may drop req_valid before it is granted.
- The first WAIT cycle cannot falsely complete: start clears sqrt_valid, so it reads 0.
- The sqrt unit has no reset; the arbiter never waits on its state before granting. A new start overrides any in-flight or stale result.
- Reset mid-operation: return to IDLE next cycle, drop resp_valid, and discard the in-flight result (the next start supersedes it).
- ptr wraps from N_REQ-1 to 0.
- timeout_err stays set until rst.

Test Plan:
1. Single request: req 0, rad=144 → req_ready[0] in T, sqrt_start in T+1, resp_valid[0] at T+51, root=12, rem=0, resp_err=0.
2. Remainder case: rad=10 → root=3, rem=1. rad=0xFFFF_FFFF_FFFF_FFFF → root=0xFFFFFFFF, rem=0x1FFFFFFFE (exact integer root/remainder; a fractional-bit unit configuration scales per its fbits).
3. All four requesters valid continuously from reset → grants in order 0,1,2,3,0; each response goes to the correct one-hot resp_valid bit with its own root.
4. Backpressure: resp_ready[1]=0 for 20 cycles → resp fields stable, no new req_ready, then grant to the next requester after the handshake.
5. Hung unit model (sqrt_busy stuck 1) → resp_valid[owner] with resp_err=1, root=rem=0 at WAIT cycle TIMEOUT; timeout_err stays 1; the next request proceeds normally.
6. rst asserted in WAIT → all outputs at reset values next cycle; a new request then returns the correct result with no stale data.
